// File: rtl/uart_bus_port.sv
// 68000 register window for the monitor UART bridge.
// DATA/STATUS decode, DTACK, TX FIFO drain and RX capture.
module uart_bus_port #(
  parameter logic [23:0] BASE_ADDR = 24'hFFF000,
  parameter int          FIFO_LOG2 = 2
) (
  input  logic        MCLK_IN,
  input  logic        RUN_IN,
  input  logic        AS_IN,
  input  logic        RW_IN,
  input  logic        LDS_IN,
  input  logic [23:0] ADDR_IN,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        DTACK,
  input  logic        UART_SEND_BUSY_IN,
  input  logic        UART_RECEIVED_IN,
  input  logic [7:0]  UART_RECEIVE_BYTE_IN,
  output logic        UART_SEND_TRIGGER,
  output logic [7:0]  UART_SEND_BYTE,
  output logic        UART_RECEIVE_CAPTURE
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW = (FIFO_LOG2 > 0) ? FIFO_LOG2 : 1;
  localparam int CW = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {
    B_IDLE, B_ACT, B_ACK
  } bus_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_TRIG, S_WAIT_HI, S_WAIT_LO
  } snd_e;

  bus_e bus_q, bus_d;
  snd_e snd_q, snd_d;

  logic busy_m_q, busy_s_q;
  logic rx_m_q, rx_s_q;
  logic rd_q, lds_q, sel_q;
  logic [15:0] rdata_q, rdata_d;
  logic ovr_q, ovr_d;
  logic [1:0] cap_q, cap_d;
  logic [2:0] hold_q, hold_d;
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] byte_q, byte_d;

  logic hit, full, empty, rx_valid;
  logic act, push_req, push, pop;
  logic [2:0] cnt3;
  logic [15:0] status;
  logic unused_ok;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_ok = ^{DATA_IN[15:8], ADDR_IN[0]};

  assign hit   = ADDR_IN[23:2] == BASE_ADDR[23:2];
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign cnt3  = (32'(cnt_q) > 32'd7) ? 3'd7
                                      : 3'(cnt_q);
  // Holdoff masks the stale synchronized level
  assign rx_valid = rx_s_q && (hold_q == 3'd0);
  assign status = {8'h00, 1'b0, cnt3, ovr_q,
                   empty, full, rx_valid};

  assign act      = (bus_q == B_ACT) && lds_q;
  assign push_req = act && !rd_q && !sel_q;
  assign push     = push_req && !full;
  assign pop      = (snd_q == S_IDLE) && !empty
                    && !busy_s_q;

  assign DTACK    = bus_q != B_ACK;
  assign DATA_OE  = (bus_q == B_ACK) && rd_q;
  assign DATA_OUT = rdata_q;

  assign UART_SEND_TRIGGER    = snd_q == S_TRIG;
  assign UART_SEND_BYTE       = byte_q;
  assign UART_RECEIVE_CAPTURE = cap_q != 2'd0;

  always_comb begin
    bus_d = bus_q;
    unique case (bus_q)
      B_IDLE: if (!AS_IN && hit) bus_d = B_ACT;
      B_ACT:  bus_d = B_ACK;
      B_ACK:  if (AS_IN) bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    ovr_d   = ovr_q;
    cap_d   = (cap_q != 2'd0) ? cap_q - 2'd1 : cap_q;
    hold_d  = (hold_q != 3'd0) ? hold_q - 3'd1
                               : hold_q;
    if (bus_q == B_ACT) begin
      rdata_d = 16'h0000;
      if (act && rd_q) begin
        rdata_d = sel_q ? status
                        : {8'h00, UART_RECEIVE_BYTE_IN};
      end
    end
    if (push_req && full) ovr_d = 1'b1;
    if (act && !rd_q && sel_q && DATA_IN[3])
      ovr_d = 1'b0;
    if (act && rd_q && !sel_q && rx_valid) begin
      cap_d  = 2'd2;
      hold_d = 3'd6;
    end
  end

  always_comb begin
    snd_d  = snd_q;
    tmr_d  = tmr_q;
    byte_d = byte_q;
    unique case (snd_q)
      S_IDLE: begin
        if (pop) begin
          byte_d = mem[rp_q];
          snd_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        snd_d = S_TRIG;
        tmr_d = 8'd0;
      end
      S_TRIG: begin
        if (tmr_q == 8'd1) begin
          snd_d = S_WAIT_HI;
          tmr_d = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_WAIT_HI: begin
        if (busy_s_q) snd_d = S_WAIT_LO;
        else if (tmr_q == 8'd254) snd_d = S_IDLE;
        else tmr_d = tmr_q + 8'd1;
      end
      S_WAIT_LO: if (!busy_s_q) snd_d = S_IDLE;
      default: snd_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK_IN) begin
    if (push) mem[wp_q] <= DATA_IN[7:0];
  end

  always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      busy_m_q <= 1'b0;
      busy_s_q <= 1'b0;
      rx_m_q   <= 1'b0;
      rx_s_q   <= 1'b0;
      bus_q    <= B_IDLE;
      rd_q     <= 1'b0;
      lds_q    <= 1'b0;
      sel_q    <= 1'b0;
      rdata_q  <= 16'h0000;
      ovr_q    <= 1'b0;
      cap_q    <= 2'd0;
      hold_q   <= 3'd0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      snd_q    <= S_IDLE;
      tmr_q    <= 8'd0;
      byte_q   <= 8'h00;
    end else begin
      busy_m_q <= UART_SEND_BUSY_IN;
      busy_s_q <= busy_m_q;
      rx_m_q   <= UART_RECEIVED_IN;
      rx_s_q   <= rx_m_q;
      bus_q    <= bus_d;
      if (bus_q == B_IDLE) begin
        rd_q  <= RW_IN;
        lds_q <= ~LDS_IN;
        sel_q <= ADDR_IN[1];
      end
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      cap_q   <= cap_d;
      hold_q  <= hold_d;
      if (push) wp_q <= inc(wp_q);
      if (pop)  rp_q <= inc(rp_q);
      if (push && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      snd_q  <= snd_d;
      tmr_q  <= tmr_d;
      byte_q <= byte_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_port.sv
// Directed bench for uart_bus_port.
// Includes a small monitor send-side model.
module tb_uart_bus_port;

  localparam logic [23:0] BASE = 24'hFFF000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        as_n = 1'b1;
  logic        rw = 1'b1;
  logic        lds_n = 1'b1;
  logic [23:0] addr = 24'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        oe, dtack;
  logic        busy_hold = 1'b0;
  logic        busy_mdl = 1'b0;
  logic        rx_in = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        trig, cap;
  logic [7:0]  sbyte;

  int tests = 0;
  int fails = 0;
  int cap_edges = 0;
  int cap_hi = 0;
  bit mdl_en = 1'b0;
  logic [7:0] sent_q [$];

  always #5 clk = ~clk;

  uart_bus_port #(.BASE_ADDR(BASE), .FIFO_LOG2(2)) dut (
    .MCLK_IN(clk),
    .RUN_IN(rst_n),
    .AS_IN(as_n),
    .RW_IN(rw),
    .LDS_IN(lds_n),
    .ADDR_IN(addr),
    .DATA_IN(wdata),
    .DATA_OUT(rdata),
    .DATA_OE(oe),
    .DTACK(dtack),
    .UART_SEND_BUSY_IN(busy_hold | busy_mdl),
    .UART_RECEIVED_IN(rx_in),
    .UART_RECEIVE_BYTE_IN(rx_byte),
    .UART_SEND_TRIGGER(trig),
    .UART_SEND_BYTE(sbyte),
    .UART_RECEIVE_CAPTURE(cap)
  );

  always @(posedge cap) cap_edges++;
  always @(negedge clk) if (cap) cap_hi++;

  initial begin
    forever begin
      @(posedge trig);
      if (mdl_en) begin
        sent_q.push_back(sbyte);
        repeat (2) @(negedge clk);
        busy_mdl = 1'b1;
        repeat (10) @(negedge clk);
        busy_mdl = 1'b0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic bus(input logic r,
                     input logic [23:0] a,
                     input logic [15:0] d,
                     input logic l,
                     output logic [15:0] q,
                     output int lat,
                     output logic oe_early,
                     output logic oe_ack,
                     output logic [1:0] post);
    @(negedge clk);
    addr = a; wdata = d; rw = r; lds_n = l;
    as_n = 1'b0;
    lat = 0; oe_early = 1'b0;
    while (dtack && lat < 10) begin
      @(negedge clk);
      lat++;
      if (dtack && oe) oe_early = 1'b1;
    end
    q = rdata;
    oe_ack = oe;
    as_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    post = {dtack, oe};
  endtask

  logic [15:0] q;
  int lat, n, w;
  logic oe_e, oe_a;
  logic [1:0] post;

  task automatic rd_status(input string tag,
                           input logic [15:0] exp);
    logic [15:0] v; int l; logic e, k;
    logic [1:0] p;
    bus(1'b1, BASE + 24'd2, 16'h0, 1'b0,
        v, l, e, k, p);
    check({tag, "_lat"}, 16'(l), 16'd2);
    check(tag, v, exp);
  endtask

  task automatic wr(input logic [23:0] a,
                    input logic [15:0] d);
    logic [15:0] v; int l; logic e, k;
    logic [1:0] p;
    bus(1'b0, a, d, 1'b0, v, l, e, k, p);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dtack", 16'(dtack), 16'd1);
    check("rst_oe", 16'(oe), 16'd0);
    check("rst_dout", rdata, 16'h0000);
    check("rst_trig", 16'(trig), 16'd0);
    check("rst_sbyte", 16'(sbyte), 16'h00);
    check("rst_cap", 16'(cap), 16'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bus(1'b1, BASE + 24'd2, 16'h0, 1'b0,
        q, lat, oe_e, oe_a, post);
    check("st0", q, 16'h0004);
    check("st0_lat", 16'(lat), 16'd2);
    check("st0_oe_early", 16'(oe_e), 16'd0);
    check("st0_oe_ack", 16'(oe_a), 16'd1);
    check("st0_post", 16'(post), 16'b10);

    wr(BASE, 16'h0041);
    n = 0;
    while (!trig && n < 20) begin
      @(negedge clk); n++;
    end
    check("t2_trig_seen", 16'(trig), 16'd1);
    check("t2_byte", 16'(sbyte), 16'h41);
    w = 0;
    while (trig && w < 10) begin
      @(negedge clk); w++;
    end
    check("t2_trig_w", 16'(w), 16'd2);
    busy_hold = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (trig) n++;
    end
    check("t2_no_retrig", 16'(n), 16'd0);
    busy_hold = 1'b0;
    repeat (5) @(negedge clk);
    rd_status("t2_st", 16'h0004);

    busy_hold = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 5; i++)
      wr(BASE, 16'(i));
    rd_status("t3_full", 16'h004A);
    mdl_en = 1'b1;
    busy_hold = 1'b0;
    n = 0;
    while (sent_q.size() < 4 && n < 600) begin
      @(negedge clk); n++;
    end
    repeat (100) @(negedge clk);
    check("t3_nsent", 16'(sent_q.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent_q.size())
        check("t3_order", 16'(sent_q[i]), 16'(i + 1));
      else
        check("t3_order", 16'hDEAD, 16'(i + 1));
    end
    mdl_en = 1'b0;
    rd_status("t3_ovr", 16'h000C);
    wr(BASE + 24'd2, 16'h0008);
    rd_status("t3_clr", 16'h0004);

    rx_byte = 8'h5A;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    rd_status("t4_rxv", 16'h0005);
    cap_edges = 0; cap_hi = 0;
    bus(1'b1, BASE, 16'h0, 1'b0,
        q, lat, oe_e, oe_a, post);
    check("t4_rd1", q, 16'h005A);
    bus(1'b1, BASE, 16'h0, 1'b0,
        q, lat, oe_e, oe_a, post);
    check("t4_rd2", q, 16'h005A);
    repeat (4) @(negedge clk);
    check("t4_cap_edges", 16'(cap_edges), 16'd1);
    check("t4_cap_w", 16'(cap_hi), 16'd2);
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rd_status("t4_st", 16'h0004);

    busy_hold = 1'b1;
    repeat (3) @(negedge clk);
    wr(BASE, 16'h0011);
    wr(BASE, 16'h0022);
    wr(BASE, 16'h0033);
    busy_hold = 1'b0;
    n = 0;
    while (!trig && n < 50) begin
      @(negedge clk); n++;
    end
    check("t5_trig_seen", 16'(trig), 16'd1);
    rst_n = 1'b0;
    #1;
    check("t5_trig_drop", 16'(trig), 16'd0);
    check("t5_dtack", 16'(dtack), 16'd1);
    check("t5_sbyte", 16'(sbyte), 16'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (trig) n++;
    end
    check("t5_no_trig", 16'(n), 16'd0);
    rd_status("t5_st", 16'h0004);

    bus(1'b0, BASE + 24'd4, 16'h0099, 1'b0,
        q, lat, oe_e, oe_a, post);
    check("t6_miss_lat", 16'(lat), 16'd10);
    check("t6_miss_dtack", 16'(post), 16'b10);
    rd_status("t6_miss_st", 16'h0004);
    bus(1'b0, BASE, 16'h0077, 1'b1,
        q, lat, oe_e, oe_a, post);
    check("t6_uds_wlat", 16'(lat), 16'd2);
    rd_status("t6_uds_st", 16'h0004);
    bus(1'b1, BASE + 24'd2, 16'h0, 1'b1,
        q, lat, oe_e, oe_a, post);
    check("t6_uds_rlat", 16'(lat), 16'd2);
    check("t6_uds_rd", q, 16'h0000);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
